// File: rtl/fish_motion_gen.sv
// Per-fish motion engine: tick prescaler, speed/zig-zag stepping, position tracking,
// hook-follow and screen-edge escape. One instance per fish.
module fish_motion_gen #(
    parameter int TICK_DIV  = 1000000,
    parameter int CNT_W     = 24,
    parameter int X_MAX     = 640,
    parameter int Y_MAX     = 480,
    parameter int ZIG_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] h,
    input  logic [9:0] v,
    input  logic [1:0] way,
    input  logic       appear,
    input  logic [2:0] movetype,
    input  logic       hooked,
    input  logic [9:0] mouse_y,
    output logic [9:0] x_pos,
    output logic [9:0] y_pos,
    output logic [2:0] hm,
    output logic [2:0] vm,
    output logic       h_dir,
    output logic       v_dir,
    output logic       step_valid,
    output logic       escaped,
    output logic [1:0] dbg_state
);
    localparam int ZIG_W = (ZIG_TICKS > 1) ? $clog2(ZIG_TICKS) : 1;

    typedef enum logic [1:0] {S_IDLE, S_SWIM, S_HOOKED, S_ESCAPED} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ZIG_W-1:0]  zig_q, zig_d;
    logic              zig_dir_q, zig_dir_d;
    logic [9:0]        x_q, x_d, y_q, y_d;
    logic [2:0]        hm_q, hm_d, vm_q, vm_d;
    logic              h_dir_q, h_dir_d, v_dir_q, v_dir_d;
    logic              step_valid_q, step_valid_d, escaped_q, escaped_d;

    logic              tick, esc, wob_eff, zig_wrap;
    logic [2:0]        step, hook_amt;
    logic [10:0]       x11, y11, step11;
    logic [9:0]        hook_diff;

    assign tick   = (cnt_q == CNT_W'(TICK_DIV - 1));
    assign step   = {1'b0, movetype[1:0]} + 3'd1;
    assign x11    = {1'b0, x_q};
    assign y11    = {1'b0, y_q};
    assign step11 = {8'd0, step};

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        zig_d        = zig_q;
        zig_dir_d    = zig_dir_q;
        x_d          = x_q;
        y_d          = y_q;
        hm_d         = 3'd0;
        vm_d         = 3'd0;
        h_dir_d      = h_dir_q;
        v_dir_d      = v_dir_q;
        step_valid_d = 1'b0;
        escaped_d    = escaped_q;
        esc          = 1'b0;
        wob_eff      = 1'b0;
        zig_wrap     = 1'b0;
        hook_diff    = 10'd0;
        hook_amt     = 3'd0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (appear) begin
                    x_d       = h;
                    y_d       = v;
                    zig_d     = '0;
                    zig_dir_d = 1'b0;
                    state_d   = S_SWIM;
                end
            end
            S_SWIM: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (tick) begin
                    step_valid_d = 1'b1;
                    case (way)
                        2'd0: begin
                            hm_d = step; h_dir_d = 1'b0;
                            if (x11 < step11) begin x_d = 10'd0; esc = 1'b1; end
                            else x_d = 10'(x11 - step11);
                        end
                        2'd1: begin
                            hm_d = step; h_dir_d = 1'b1;
                            if (x11 + step11 > 11'(X_MAX - 1)) begin
                                x_d = 10'(X_MAX - 1); esc = 1'b1;
                            end else x_d = 10'(x11 + step11);
                        end
                        2'd2: begin
                            vm_d = step; v_dir_d = 1'b0;
                            if (y11 < step11) begin y_d = 10'd0; esc = 1'b1; end
                            else y_d = 10'(y11 - step11);
                        end
                        default: ;
                    endcase
                    // Wobble bounces off the screen edge instead of escaping
                    if (movetype[2] && way != 2'd3) begin
                        if (way == 2'd2) begin
                            wob_eff = zig_dir_q ? (x_q != 10'(X_MAX - 1)) : (x_q == 10'd0);
                            x_d     = wob_eff ? x_q + 10'd1 : x_q - 10'd1;
                            hm_d    = 3'd1;
                            h_dir_d = wob_eff;
                        end else begin
                            wob_eff = zig_dir_q ? (y_q != 10'(Y_MAX - 1)) : (y_q == 10'd0);
                            y_d     = wob_eff ? y_q + 10'd1 : y_q - 10'd1;
                            vm_d    = 3'd1;
                            v_dir_d = wob_eff;
                        end
                        zig_wrap  = (zig_q == ZIG_W'(ZIG_TICKS - 1));
                        zig_d     = zig_wrap ? '0 : zig_q + ZIG_W'(1);
                        zig_dir_d = wob_eff ^ zig_wrap;
                    end
                end
                if (esc) begin
                    escaped_d = 1'b1;
                    state_d   = S_ESCAPED;
                end else if (hooked) begin
                    state_d = S_HOOKED;
                end
            end
            S_HOOKED: begin
                cnt_d = tick ? '0 : cnt_q + CNT_W'(1);
                if (tick) begin
                    step_valid_d = 1'b1;
                    if (mouse_y > y_q) begin
                        hook_diff = mouse_y - y_q; v_dir_d = 1'b1;
                    end else if (mouse_y < y_q) begin
                        hook_diff = y_q - mouse_y; v_dir_d = 1'b0;
                    end
                    hook_amt = (hook_diff < {7'd0, step}) ? hook_diff[2:0] : step;
                    vm_d     = hook_amt;
                    y_d      = v_dir_d ? y_q + {7'd0, hook_amt} : y_q - {7'd0, hook_amt};
                end
                if (!hooked) state_d = S_SWIM;
            end
            default: cnt_d = '0;
        endcase

        // Despawn overrides any motion computed above; position and dirs hold.
        if (!appear) begin
            state_d      = S_IDLE;
            cnt_d        = '0;
            zig_d        = zig_q;
            zig_dir_d    = zig_dir_q;
            x_d          = x_q;
            y_d          = y_q;
            hm_d         = 3'd0;
            vm_d         = 3'd0;
            h_dir_d      = h_dir_q;
            v_dir_d      = v_dir_q;
            step_valid_d = 1'b0;
            escaped_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            zig_q        <= '0;
            zig_dir_q    <= 1'b0;
            x_q          <= 10'd0;
            y_q          <= 10'd0;
            hm_q         <= 3'd0;
            vm_q         <= 3'd0;
            h_dir_q      <= 1'b0;
            v_dir_q      <= 1'b0;
            step_valid_q <= 1'b0;
            escaped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            zig_q        <= zig_d;
            zig_dir_q    <= zig_dir_d;
            x_q          <= x_d;
            y_q          <= y_d;
            hm_q         <= hm_d;
            vm_q         <= vm_d;
            h_dir_q      <= h_dir_d;
            v_dir_q      <= v_dir_d;
            step_valid_q <= step_valid_d;
            escaped_q    <= escaped_d;
        end
    end

    assign x_pos      = x_q;
    assign y_pos      = y_q;
    assign hm         = hm_q;
    assign vm         = vm_q;
    assign h_dir      = h_dir_q;
    assign v_dir      = v_dir_q;
    assign step_valid = step_valid_q;
    assign escaped    = escaped_q;
    assign dbg_state  = state_q;
endmodule

// File: tb/tb_fish_motion_gen.sv
// Directed bench for fish_motion_gen: swim, escape, zig-zag, hook follow, despawn and async reset.
module tb_fish_motion_gen;
    localparam int TICK_DIV  = 4;
    localparam int CNT_W     = 3;
    localparam int X_MAX     = 640;
    localparam int Y_MAX     = 480;
    localparam int ZIG_TICKS = 2;

    localparam logic [1:0] ST_IDLE = 2'd0, ST_SWIM = 2'd1, ST_HOOKED = 2'd2, ST_ESC = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] h, v, mouse_y;
    logic [1:0] way;
    logic       appear, hooked;
    logic [2:0] movetype;
    logic [9:0] x_pos, y_pos;
    logic [2:0] hm, vm;
    logic       h_dir, v_dir, step_valid, escaped;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_errors = 0;
    logic [9:0] exp_q[$];

    fish_motion_gen #(
        .TICK_DIV(TICK_DIV), .CNT_W(CNT_W), .X_MAX(X_MAX), .Y_MAX(Y_MAX), .ZIG_TICKS(ZIG_TICKS)
    ) dut (
        .clk(clk), .rst(rst), .h(h), .v(v), .way(way), .appear(appear),
        .movetype(movetype), .hooked(hooked), .mouse_y(mouse_y),
        .x_pos(x_pos), .y_pos(y_pos), .hm(hm), .vm(vm), .h_dir(h_dir), .v_dir(v_dir),
        .step_valid(step_valid), .escaped(escaped), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the negedge where step_valid is seen; cyc counts negedges waited.
    task automatic wait_step(input string tag, output int cyc);
        bit found;
        found = 1'b0;
        cyc   = 0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            cyc++;
            if (step_valid) found = 1'b1;
        end
        check({tag, "_step_seen"}, 32'(found), 32'd1);
    endtask

    task automatic spawn(input logic [9:0] hh, input logic [9:0] vv, input logic [1:0] ww,
                         input logic [2:0] mt, input logic hk);
        h = hh; v = vv; way = ww; movetype = mt; hooked = hk; appear = 1'b1;
    endtask

    initial begin : main
        int cyc;
        int pulses;
        int zx[5] = '{11, 12, 13, 14, 15};
        int zy[5] = '{1, 2, 1, 0, 1};
        int zd[5] = '{1, 1, 0, 0, 1};
        int hy[4] = '{296, 292, 290, 290};
        int hv[4] = '{4, 4, 2, 0};

        rst = 1'b1; appear = 1'b0; hooked = 1'b0; h = '0; v = '0; way = '0;
        movetype = '0; mouse_y = '0;
        repeat (3) @(negedge clk);
        check("reset_xy", {x_pos, y_pos}, 32'd0);
        check("reset_mag", {hm, vm, h_dir, v_dir}, 32'd0);
        check("reset_flags", {step_valid, escaped, dbg_state}, 32'd0);
        rst = 1'b0;

        // Steady swim right at speed 2
        spawn(10'd100, 10'd200, 2'd1, 3'b001, 1'b0);
        exp_q.push_back(10'd102); exp_q.push_back(10'd104); exp_q.push_back(10'd106);
        for (int i = 0; i < 3; i++) begin
            wait_step("swim", cyc);
            check("swim_latency", cyc, (i == 0) ? TICK_DIV + 1 : TICK_DIV);
            check("swim_x", x_pos, exp_q.pop_front());
            check("swim_y", y_pos, 32'd200);
            check("swim_hm_dir", {hm, h_dir}, {3'd2, 1'b1});
            check("swim_vm", vm, 32'd0);
        end
        @(negedge clk);
        check("swim_idle_gap", {step_valid, hm, h_dir}, {1'b0, 3'd0, 1'b1});

        // Despawn then respawn at a new location, swim left at speed 4 to escape
        appear = 1'b0;
        @(negedge clk);
        check("despawn_state", dbg_state, ST_IDLE);
        check("despawn_outs", {step_valid, hm, vm, x_pos}, {1'b0, 3'd0, 3'd0, 10'd106});
        spawn(10'd5, 10'd50, 2'd0, 3'b011, 1'b0);
        @(negedge clk);
        check("respawn_xy", {x_pos, y_pos}, {10'd5, 10'd50});
        check("respawn_state", dbg_state, ST_SWIM);
        wait_step("left1", cyc);
        check("left1_x", x_pos, 32'd1);
        check("left1_hm", {hm, h_dir, escaped}, {3'd4, 1'b0, 1'b0});
        wait_step("left2", cyc);
        check("left2_x", x_pos, 32'd0);
        check("left2_esc", escaped, 32'd1);
        check("left2_state", dbg_state, ST_ESC);
        pulses = 0;
        repeat (12) begin
            @(negedge clk);
            if (step_valid) pulses++;
        end
        check("esc_no_steps", pulses, 32'd0);
        check("esc_held", escaped, 32'd1);
        appear = 1'b0;
        @(negedge clk);
        check("esc_cleared", {escaped, dbg_state}, {1'b0, ST_IDLE});

        // Zig-zag at the top edge: wobble must bounce, never escape
        spawn(10'd10, 10'd0, 2'd1, 3'b100, 1'b0);
        for (int i = 0; i < 5; i++) begin
            wait_step("zig", cyc);
            check("zig_x", x_pos, zx[i]);
            check("zig_y", y_pos, zy[i]);
            check("zig_mag", {hm, vm, v_dir}, {3'd1, 3'd1, 1'(zd[i])});
            check("zig_esc", escaped, 32'd0);
        end
        appear = 1'b0;
        @(negedge clk);

        // Hooked on the spawn cycle: spawn ignores it, then follow mouse_y
        spawn(10'd50, 10'd300, 2'd1, 3'b011, 1'b1);
        mouse_y = 10'd290;
        @(negedge clk);
        check("hook_spawn_state", dbg_state, ST_SWIM);
        for (int i = 0; i < 4; i++) begin
            wait_step("hook", cyc);
            check("hook_y", y_pos, hy[i]);
            check("hook_vm_dir", {vm, v_dir}, {3'(hv[i]), 1'b0});
            check("hook_x_frozen", {x_pos, hm}, {10'd50, 3'd0});
        end
        hooked = 1'b0;
        wait_step("unhook", cyc);
        check("unhook_x", x_pos, 32'd54);
        check("unhook_mag", {hm, h_dir, y_pos}, {3'd4, 1'b1, 10'd290});

        // Asynchronous reset between edges mid-swim
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("arst_xy", {x_pos, y_pos}, 32'd0);
        check("arst_flags", {step_valid, escaped, hm, vm, h_dir, v_dir, dbg_state}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        spawn(10'd100, 10'd200, 2'd1, 3'b001, 1'b0);
        wait_step("post_rst", cyc);
        check("post_rst_latency", cyc, TICK_DIV + 1);
        check("post_rst_x", {x_pos, y_pos}, {10'd102, 10'd200});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/fish_motion_gen.md
# fish_motion_gen

Parametrised per-fish motion engine for the fishing game. It generalises the fixed-rate fish step generator into a block with:
- a programmable tick divider and selectable speed;
- an optional zig-zag wobble;
- on-chip position tracking, with hooked-follow and screen-edge escape behaviour.

One instance is used per fish. The renderer consumes its `x_pos`/`y_pos`, and the game controller consumes `escaped` and the step outputs.

## Interface
Parameters:
- `TICK_DIV`, 1000000, clock cycles per motion tick (≥2)
- `CNT_W`, 24, prescaler width (must hold `TICK_DIV-1`)
- `X_MAX`, 640, screen width in pixels
- `Y_MAX`, 480, screen height in pixels
- `ZIG_TICKS`, 8, ticks between wobble reversals (≥1)

Ports:
- `clk`  in  1  system clock; one clock, all logic on the rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `h`  in  10  spawn x, sampled on spawn
- `v`  in  10  spawn y, sampled on spawn
- `way`  in  2  0 = swim left, 1 = swim right, 2 = swim up, 3 = hold
- `appear`  in  1  1 = fish exists; 0 forces IDLE
- `movetype`  in  3  [1:0] speed (step = value+1 px/tick); [2] zig-zag enable
- `hooked`  in  1  fish caught by hook
- `mouse_y`  in  10  hook y target while hooked
- `x_pos`  out  10  current x
- `y_pos`  out  10  current y
- `hm`  out  3  horizontal step magnitude this step
- `vm`  out  3  vertical step magnitude this step
- `h_dir`  out  1  0 = −x, 1 = +x
- `v_dir`  out  1  0 = −y (up), 1 = +y
- `step_valid`  out  1  one-cycle pulse: position and step outputs just updated
- `escaped`  out  1  fish left the screen; held until `appear` = 0

## Operation
States are IDLE, SWIM, HOOKED and ESCAPED.

**IDLE**
- If `appear` = 1, the next edge loads `x_pos`=`h`, `y_pos`=`v`, clears the prescaler and the zig counter, and enters SWIM.

**Any state**
- If `appear` = 0, the next edge enters IDLE. It also clears `escaped`, `hm`, `vm` and `step_valid`. Position is held.

**Prescaler and tick**
- The prescaler counts 0..`TICK_DIV`−1 in SWIM and HOOKED; it is held at 0 in IDLE and ESCAPED.
- tick = (cnt == `TICK_DIV`−1); the counter wraps to 0 on tick.
- step = `movetype`[1:0]+1, range 1..4.

**SWIM, on tick**
- way 0: x −= step. If x < step, then x = 0, `escaped` is set and the state becomes ESCAPED.
- way 1: x += step. If x+step > `X_MAX`−1, then x = `X_MAX`−1, `escaped` is set and the state becomes ESCAPED.
- way 2: y −= step. If y < step, then y = 0, `escaped` is set and the state becomes ESCAPED.
- way 3: no motion; `step_valid` still pulses with `hm`=`vm`=0.
- Main-axis magnitude goes to `hm` (way 0/1) or `vm` (way 2), with its direction bit.
- Zig-zag (`movetype`[2]=1, way 0–2): a 1-px wobble on the cross axis (`vm` for way 0/1, `hm` for way 2).
  - The wobble direction toggles when zig_cnt wraps at `ZIG_TICKS`−1.
  - If the wobble would leave [0, `Y_MAX`−1] or [0, `X_MAX`−1], its direction flips and it moves 1 px the other way that tick. The wobble never causes escape.
  - In way 3, zig-zag is ignored.
- If `hooked`=1, the next edge enters HOOKED; the prescaler is not cleared.

**HOOKED, on tick**
- x is frozen and `hm`=0.
- y moves toward `mouse_y` by min(step, |`mouse_y` − y); `vm` = that amount and `v_dir` = the sign. If y == `mouse_y`, then `vm`=0.
- If `hooked`=0, the next edge returns to SWIM. The zig counter resumes from its held value.

**ESCAPED**
- No motion and `step_valid`=0. Exit only via `appear`=0.

**Arithmetic**
- All position math is done at 11 bits before clamping; no wrap-around ever occurs.

**Simultaneous events**
- `appear`=0 wins over everything.
- Escape detection wins over `hooked` on the same tick.
- Spawn ignores `hooked` for the spawn cycle.

## Timing
- Reset values: state IDLE, cnt 0, zig_cnt 0, `x_pos`=`y_pos`=0, `hm`=`vm`=0, `h_dir`=`v_dir`=0, `step_valid`=0, `escaped`=0.
- Tick in cycle N: `x_pos`, `y_pos`, `hm`, `vm`, the dirs and `step_valid` update at the edge ending N, i.e. they are visible in N+1.
- `step_valid` is high only in N+1. `hm`/`vm` are nonzero only while `step_valid`=1 and are zero otherwise; dirs hold their last value.
- `escaped` rises in the same cycle as the final `step_valid` pulse.
- Steady swim: one step every `TICK_DIV` cycles. The first step comes `TICK_DIV` cycles after the SWIM entry edge.
- Reset asserted mid-operation: immediate return to the reset values, independent of the clock.

## Test plan
- `TICK_DIV`=4; spawn h=100, v=200, way=1, `movetype`=3'b001 -> `step_valid` every 4 cycles, `hm`=2, `h_dir`=1, x goes 102, 104, …; y stays 200.
- way=0, h=5, speed 4 -> x=1 on the first step; the second step gives x=0, `escaped`=1, state ESCAPED; then no further `step_valid`.
- way=1, `movetype`=3'b100, `ZIG_TICKS`=2, v=0 -> `hm`=1 each step; the wobble flips at the top edge so y stays ≥0; `vm`=1 each step; no escape.
- SWIM at y=300, assert `hooked`, `mouse_y`=290, speed 4 -> `vm`=4, 4, 2 with `v_dir`=0, x frozen; then `vm`=0 while y=290; deassert `hooked` -> resumes swimming.
- Drop `appear` mid-swim -> IDLE next edge, outputs zeroed; reassert with new h/v -> respawn at the new coordinates.
- Assert `rst` between edges mid-swim -> all outputs reach their reset values immediately; after release, behaviour is the same as after power-on.
